triangle_uploader: RTL and testbench

Host-side end of the bootloader serial protocol. On `start`, it reads triangles from a local triangle memory and streams them byte by byte into a UART transmitter: a 32-bit triangle count first, then 18 bytes per triangle. Independently, it collects the 3-byte RGB pixel stream coming back from the bootloader's frame-buffer transmit path and writes each pixel to a capture memory. It sits between a host UART instance and test/host logic, replacing hand-driven byte sequencing.

---
 rtl/triangle_uploader_if.sv | 37 +++
 rtl/triangle_uploader.sv | 211 +++++++++++++++++++++
 tb/tb_triangle_uploader.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/triangle_uploader_if.sv
`default_nettype none
// ============================================================================
//  Module   : triangle_uploader_if
//  Purpose  : Byte-level link between triangle_uploader and a host UART.
//             The master side sequences outgoing bytes and consumes incoming
//             ones; the slave side is the UART instance.
//  Revision : 1.0 - initial release
// ============================================================================
interface triangle_uploader_if;

  logic [7:0] tx_data;     // byte to transmit
  logic       trmt;        // one-cycle transmit strobe
  logic       tx_done;     // transmit-complete level from the UART
  logic [7:0] rx_data;     // received byte
  logic       rx_rdy;      // received byte available
  logic       clr_rx_rdy;  // consume the received byte

  modport master (
    output tx_data,
    output trmt,
    output clr_rx_rdy,
    input  tx_done,
    input  rx_data,
    input  rx_rdy
  );

  modport slave (
    input  tx_data,
    input  trmt,
    input  clr_rx_rdy,
    output tx_done,
    output rx_data,
    output rx_rdy
  );

endinterface
`default_nettype wire

// File: rtl/triangle_uploader.sv
`default_nettype none
// ============================================================================
//  Module   : triangle_uploader
//  Purpose  : Host-side end of the bootloader serial protocol. Streams a
//             32-bit triangle count followed by 18 bytes per triangle into a
//             UART transmitter, one byte outstanding at a time, and
//             independently assembles the returning R,G,B byte stream into
//             pixel writes for a capture memory.
//  Revision : 1.0 - initial release
// ============================================================================
module triangle_uploader #(
  parameter int NUM_PIXELS = 307200,
  parameter int PIX_AW     = 21
) (
  input  logic                clk,
  input  logic                reset,

  // Upload control
  input  logic                start,
  input  logic [31:0]         num_tris,
  output logic                busy,
  output logic                upload_done,

  // Triangle memory (combinational read)
  output logic [31:0]         tri_rd_addr,
  input  logic [143:0]        tri_rd_data,

  // UART byte link
  triangle_uploader_if.master uart,

  // Pixel capture
  output logic                pix_valid,
  output logic [PIX_AW-1:0]   pix_addr,
  output logic [23:0]         pix_rgb,
  output logic                frame_done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_LOAD = 3'd1;
  localparam logic [2:0] c_SEND = 3'd2;
  localparam logic [2:0] c_WAIT = 3'd3;
  localparam logic [2:0] c_DONE = 3'd4;

  localparam logic [4:0] c_COUNT_BYTES = 5'd4;
  localparam logic [4:0] c_TRI_BYTES   = 5'd18;

  localparam logic [PIX_AW-1:0] c_LAST_PIX = PIX_AW'(NUM_PIXELS - 1);
  localparam logic [PIX_AW-1:0] c_PIX_ONE  = PIX_AW'(1);

  // --------------------------------------------------------------------------
  // TX path state
  // --------------------------------------------------------------------------
  logic [2:0]   r_state;
  logic [31:0]  r_num_tris;    // count latched on the accepted start
  logic [31:0]  r_tri_idx;     // next triangle to load
  logic [143:0] r_shift;       // outgoing bytes, low byte goes first
  logic [4:0]   r_byte_cnt;    // bytes still to send from r_shift
  logic         r_tx_done_q;   // previous tx_done level for edge detection

  logic         w_tx_done_rise;
  logic         w_tris_left;

  // A byte is complete only on a fresh rising edge of tx_done, so a level
  // left high from the previous byte can never release the next one early.
  assign w_tx_done_rise = uart.tx_done & ~r_tx_done_q;
  assign w_tris_left    = (r_tri_idx < r_num_tris);

  // Registered copy of tx_done used for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_done_q <= 1'b0;
    end else begin
      r_tx_done_q <= uart.tx_done;
    end
  end

  // Upload sequencer: count bytes, then each triangle word, one byte per
  // tx_done handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_num_tris <= '0;
      r_tri_idx  <= '0;
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_num_tris <= num_tris;
            r_tri_idx  <= '0;
            r_shift    <= {112'd0, num_tris};
            r_byte_cnt <= c_COUNT_BYTES;
            r_state    <= c_SEND;
          end
        end

        c_SEND: begin
          // The strobe for the current low byte is driven in this state;
          // advance to the next byte now so it is ready after the handshake.
          r_shift    <= {8'd0, r_shift[143:8]};
          r_byte_cnt <= r_byte_cnt - 5'd1;
          r_state    <= c_WAIT;
        end

        c_WAIT: begin
          if (w_tx_done_rise) begin
            if (r_byte_cnt != 5'd0) begin
              r_state <= c_SEND;
            end else if (w_tris_left) begin
              r_state <= c_LOAD;
            end else begin
              r_state <= c_DONE;
            end
          end
        end

        c_LOAD: begin
          r_shift    <= tri_rd_data;
          r_byte_cnt <= c_TRI_BYTES;
          r_tri_idx  <= r_tri_idx + 32'd1;
          r_state    <= c_SEND;
        end

        c_DONE: begin
          r_state <= c_IDLE;
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign uart.trmt    = (r_state == c_SEND);
  assign uart.tx_data = r_shift[7:0];
  assign busy         = (r_state != c_IDLE);
  assign upload_done  = (r_state == c_DONE);
  assign tri_rd_addr  = r_tri_idx;

  // --------------------------------------------------------------------------
  // RX path: R, G, B bytes form one pixel write
  // --------------------------------------------------------------------------
  logic [1:0]        r_rx_cnt;      // position of the next byte in the pixel
  logic [7:0]        r_red;
  logic [7:0]        r_green;
  logic              r_pix_valid;
  logic [PIX_AW-1:0] r_pix_addr;
  logic [23:0]       r_pix_rgb;
  logic              r_frame_done;

  // The UART drops rx_rdy once it sees clr_rx_rdy, so each rx_rdy cycle is
  // exactly one new byte.
  assign uart.clr_rx_rdy = uart.rx_rdy;

  // Pixel assembly and capture-address sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_cnt     <= 2'd0;
      r_red        <= '0;
      r_green      <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_addr   <= '0;
      r_pix_rgb    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;

      // The address is held for the write cycle and advances right after,
      // so pix_addr always names the pixel that pix_valid reports.
      if (r_pix_valid) begin
        if (r_pix_addr == c_LAST_PIX) begin
          r_pix_addr <= '0;
        end else begin
          r_pix_addr <= r_pix_addr + c_PIX_ONE;
        end
      end

      if (uart.rx_rdy) begin
        case (r_rx_cnt)
          2'd0: begin
            r_red    <= uart.rx_data;
            r_rx_cnt <= 2'd1;
          end
          2'd1: begin
            r_green  <= uart.rx_data;
            r_rx_cnt <= 2'd2;
          end
          default: begin
            r_pix_rgb    <= {r_red, r_green, uart.rx_data};
            r_pix_valid  <= 1'b1;
            r_frame_done <= (r_pix_addr == c_LAST_PIX);
            r_rx_cnt     <= 2'd0;
          end
        endcase
      end
    end
  end

  assign pix_valid  = r_pix_valid;
  assign pix_addr   = r_pix_addr;
  assign pix_rgb    = r_pix_rgb;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_triangle_uploader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_triangle_uploader
//  Purpose  : Self-checking bench for triangle_uploader with a behavioural
//             UART, triangle memory and expected byte/pixel streams.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_triangle_uploader;

  localparam int NPIX = 4;
  localparam int AW   = 21;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [31:0]    num_tris = '0;
  logic [31:0]    tri_rd_addr;
  logic [143:0]   tri_rd_data;
  logic           busy, upload_done, pix_valid, frame_done;
  logic [AW-1:0]  pix_addr;
  logic [23:0]    pix_rgb;

  triangle_uploader_if u_if ();

  triangle_uploader #(.NUM_PIXELS(NPIX), .PIX_AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_tris    (num_tris),
    .busy        (busy),
    .upload_done (upload_done),
    .tri_rd_addr (tri_rd_addr),
    .tri_rd_data (tri_rd_data),
    .uart        (u_if),
    .pix_valid   (pix_valid),
    .pix_addr    (pix_addr),
    .pix_rgb     (pix_rgb),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // Triangle memory with combinational read
  logic [143:0] tri_mem [8];
  assign tri_rd_data = tri_mem[tri_rd_addr[2:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  int exp_pix_addr = 0;

  // Observations gathered by the UART model
  logic [7:0] bytes_q[$];
  int         trmt_cyc[$];
  int         rise_cyc[$];
  int         ud_cyc[$];
  int         busy_fall[$];
  bit         outstanding = 1'b0;

  // Behavioural UART: accepts a byte on trmt, raises tx_done after a random
  // delay, and flags any strobe issued while a byte is still in flight.
  initial begin
    int  countdown;
    bit  prev_busy;
    countdown = 0;
    prev_busy = 1'b0;
    u_if.tx_done = 1'b1;
    u_if.rx_rdy  = 1'b0;
    u_if.rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (upload_done === 1'b1) ud_cyc.push_back(cyc);
      if (prev_busy && busy === 1'b0) busy_fall.push_back(cyc);
      prev_busy = (busy === 1'b1);
      if (u_if.trmt === 1'b1) begin
        if (outstanding) viol++;
        bytes_q.push_back(u_if.tx_data);
        trmt_cyc.push_back(cyc);
        outstanding  = 1'b1;
        countdown    = $urandom_range(1, 5);
        u_if.tx_done = 1'b0;
      end else if (outstanding) begin
        countdown--;
        if (countdown == 0) begin
          u_if.tx_done = 1'b1;
          outstanding  = 1'b0;
          rise_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [89:0] obs_all();
    return {u_if.trmt, busy, upload_done, pix_valid, frame_done,
            u_if.tx_data, tri_rd_addr, pix_addr, pix_rgb};
  endfunction

  task automatic wait_uart_idle();
    int t = 0;
    while (outstanding && t < 50) begin @(negedge clk); t++; end
    bytes_q.delete(); trmt_cyc.delete(); rise_cyc.delete();
    ud_cyc.delete(); busy_fall.delete();
  endtask

  // Runs one upload and checks the whole byte stream and its timing
  task automatic run_upload(input int n);
    logic [7:0] exp[$];
    logic [31:0] cnt;
    int st, t, v0, gap, last;
    cnt = n;
    for (int k = 0; k < 4; k++) exp.push_back(cnt[8*k +: 8]);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 18; k++) exp.push_back(tri_mem[i][8*k +: 8]);
    wait_uart_idle();
    v0 = viol;
    @(negedge clk); start = 1'b1; num_tris = cnt; st = cyc;
    @(negedge clk); start = 1'b0; num_tris = $urandom;
    t = 0;
    while (ud_cyc.size() == 0 && t < 4000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    checks++;
    if (ud_cyc.size() != 1) begin
      failures++;
      $display("FAIL upload_done_count got=%0d exp=1 (n=%0d)", ud_cyc.size(), n);
      return;
    end
    checks++;
    if (bytes_q.size() != exp.size()) begin
      failures++;
      $display("FAIL byte_count got=%0d exp=%0d", bytes_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (bytes_q[i] !== exp[i]) begin
          failures++;
          $display("FAIL tx_byte[%0d] got=%h exp=%h", i, bytes_q[i], exp[i]);
        end
      end
      checks++;
      if (trmt_cyc[0] - st != 1) begin
        failures++;
        $display("FAIL start_to_trmt got=%0d exp=1", trmt_cyc[0] - st);
      end
      for (int i = 1; i < exp.size(); i++) begin
        gap = (i >= 4 && (i - 4) % 18 == 0) ? 2 : 1;
        checks++;
        if (trmt_cyc[i] - rise_cyc[i-1] != gap) begin
          failures++;
          $display("FAIL done_to_trmt[%0d] got=%0d exp=%0d", i, trmt_cyc[i] - rise_cyc[i-1], gap);
        end
      end
      last = rise_cyc[rise_cyc.size()-1];
      checks++;
      if (ud_cyc[0] != last + 1) begin
        failures++;
        $display("FAIL upload_done_time got=%0d exp=%0d", ud_cyc[0], last + 1);
      end
      checks++;
      if (busy_fall.size() != 1 || busy_fall[0] != last + 2) begin
        failures++;
        $display("FAIL busy_fall got=%0d exp=%0d", busy_fall.size() > 0 ? busy_fall[0] : -1, last + 2);
      end
    end
    checks++;
    if (viol != v0) begin
      failures++;
      $display("FAIL trmt_overlap got=%0d exp=0", viol - v0);
    end
  endtask

  task automatic send_rx_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk); u_if.rx_rdy = 1'b1; u_if.rx_data = b;
    @(negedge clk); u_if.rx_rdy = 1'b0; u_if.rx_data = 8'($urandom);
  endtask

  // Sends R,G,B and checks the resulting pixel write at the model's address
  task automatic send_pixel(input logic [23:0] rgb);
    logic [7:0] b;
    int nxt;
    nxt = (exp_pix_addr + 1) % NPIX;
    for (int i = 0; i < 3; i++) begin
      b = rgb[23 - 8*i -: 8];
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk); u_if.rx_rdy = 1'b1; u_if.rx_data = b;
      #1;
      checks++;
      if (u_if.clr_rx_rdy !== 1'b1) begin
        failures++;
        $display("FAIL clr_rx_rdy got=%b exp=1", u_if.clr_rx_rdy);
      end
      @(negedge clk); u_if.rx_rdy = 1'b0; u_if.rx_data = 8'($urandom);
      checks++;
      if (i < 2) begin
        if (pix_valid !== 1'b0 || frame_done !== 1'b0) begin
          failures++;
          $display("FAIL early_pix_valid got=%b%b exp=00", pix_valid, frame_done);
        end
      end else if (pix_valid !== 1'b1 || pix_rgb !== rgb || pix_addr !== AW'(exp_pix_addr)
                   || frame_done !== (exp_pix_addr == NPIX - 1)) begin
        failures++;
        $display("FAIL pixel_write got=v%b rgb=%h a=%0d fd=%b exp=v1 rgb=%h a=%0d fd=%b",
                 pix_valid, pix_rgb, pix_addr, frame_done, rgb, exp_pix_addr,
                 exp_pix_addr == NPIX - 1);
      end
    end
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || pix_addr !== AW'(nxt)) begin
      failures++;
      $display("FAIL pix_addr_advance got=v%b a=%0d exp=v0 a=%0d", pix_valid, pix_addr, nxt);
    end
    exp_pix_addr = nxt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_all() !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", obs_all());
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_all() !== '0) begin
      failures++;
      $display("FAIL idle_outputs got=%h exp=0", obs_all());
    end
  endtask

  task automatic test_single_triangle();
    tri_mem[0] = 144'hDAC0_FFEE_DEAD_C0DE_ABCD_1234_5678_F00D_1337;
    run_upload(1);
  endtask

  task automatic test_three_triangles();
    tri_mem[0] = {$urandom, $urandom, $urandom, $urandom, 16'h8888};
    tri_mem[1] = {$urandom, $urandom, $urandom, $urandom, 16'hCDCD};
    tri_mem[2] = {$urandom, $urandom, $urandom, $urandom, 16'h0101};
    run_upload(3);
  endtask

  task automatic test_zero_triangles();
    run_upload(0);
  endtask

  task automatic test_pixel_capture();
    send_pixel(24'h34ABCD);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) send_pixel(24'($urandom));
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < 8; i++) tri_mem[i] = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
    fork
      run_upload(2);
      begin
        repeat (20) @(negedge clk);
        start = 1'b1; num_tris = 32'd5;
        @(negedge clk);
        start = 1'b0;
      end
    join
  endtask

  task automatic test_concurrent();
    int n;
    n = $urandom_range(1, 4);
    for (int i = 0; i < 8; i++) tri_mem[i] = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
    fork
      run_upload(n);
      for (int i = 0; i < 3; i++) send_pixel(24'($urandom));
    join
  endtask

  task automatic test_reset_mid();
    int t;
    for (int i = 0; i < 3; i++) tri_mem[i] = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
    wait_uart_idle();
    @(negedge clk); start = 1'b1; num_tris = 32'd3;
    @(negedge clk); start = 1'b0;
    send_rx_byte(8'h11);
    send_rx_byte(8'h22);
    t = 0;
    while (bytes_q.size() < 8 && t < 500) begin @(negedge clk); t++; end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_all() !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h exp=0", obs_all());
    end
    reset = 1'b0;
    exp_pix_addr = 0;
    tri_mem[0] = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
    run_upload(1);
    send_pixel(24'($urandom));
  endtask

  initial begin
    test_reset();
    test_single_triangle();
    test_three_triangles();
    test_zero_triangles();
    test_pixel_capture();
    test_wrap();
    test_start_while_busy();
    test_concurrent();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
